// File: rtl/dec_key_pkg.sv
// Shared types and default parameters for the serial key-entry decoder.
package dec_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_ACTIVE,
    ST_LOCKED
  } dec_state_e;

  localparam int unsigned            DEF_KEY_LEN        = 4;
  localparam logic [DEF_KEY_LEN-1:0] DEF_KEY_VALUE      = 4'b1010;
  localparam int unsigned            DEF_MAX_TRIES      = 3;
  localparam int unsigned            DEF_LOCK_CYCLES    = 16;
  localparam int unsigned            DEF_TIMEOUT_CYCLES = 64;
  localparam int unsigned            DEF_FAIL_W         = $clog2(DEF_MAX_TRIES + 1);

endpackage

// File: rtl/key_sequence_decoder_if.sv
// Command-in / status-out bundle between the command front-end and the key decoder.
interface key_sequence_decoder_if #(
  parameter int unsigned FAIL_W = dec_key_pkg::DEF_FAIL_W
);
  logic              InputKey;
  logic              ValidCmd;
  logic              Active;
  logic              Mode;
  logic              Error;
  logic              Locked;
  logic [FAIL_W-1:0] FailCnt;

  modport master (
    output InputKey, ValidCmd,
    input  Active, Mode, Error, Locked, FailCnt
  );

  modport slave (
    input  InputKey, ValidCmd,
    output Active, Mode, Error, Locked, FailCnt
  );
endinterface

// File: rtl/dec_key_timer.sv
// Loadable down-counter; done_c is high while the count sits at zero.
module dec_key_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done_c
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_c = (cnt_q == '0);
endmodule

// File: rtl/key_sequence_decoder.sv
// Serial key-entry decoder with failed-attempt lockout and a post-unlock Mode bit.
// Optional inactivity timeout in ENTRY/ACTIVE is built when DEC_KEY_TIMEOUT_EN is defined.
module key_sequence_decoder
  import dec_key_pkg::*;
#(
  parameter int unsigned        KEY_LEN        = DEF_KEY_LEN,
  parameter logic [KEY_LEN-1:0] KEY_VALUE      = KEY_LEN'(DEF_KEY_VALUE),
  parameter int unsigned        MAX_TRIES      = DEF_MAX_TRIES,
  parameter int unsigned        LOCK_CYCLES    = DEF_LOCK_CYCLES,
  parameter int unsigned        TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                   Clk,
  input logic                   Reset,
  key_sequence_decoder_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(KEY_LEN + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

  if (KEY_LEN < 1 || MAX_TRIES < 1 || LOCK_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("key_sequence_decoder: all size parameters must be >= 1");
  end

  dec_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mis_q, mis_d;
  logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
  logic              active_q, active_d;
  logic              mode_q, mode_d;
  logic              error_q, error_d;
  logic              locked_q, locked_d;
  logic [KEY_LEN-1:0] key_shift;
  logic              bit_bad;
  logic              lock_done_c;

  // Expected bit for the current index is always the MSB of the shifted key.
  assign key_shift = KEY_VALUE << idx_q;
  assign bit_bad   = bus.InputKey ^ key_shift[KEY_LEN-1];
  assign fail_inc  = (fail_q == FAIL_W'(MAX_TRIES)) ? fail_q : fail_q + FAIL_W'(1);

  dec_key_timer #(.W(LOCK_W)) u_lock_timer (
    .clk     (Clk),
    .rst_n   (Reset),
    .load    (state_q == ST_CHECK),
    .en      (state_q == ST_LOCKED),
    .load_val(LOCK_W'(LOCK_CYCLES - 1)),
    .done_c  (lock_done_c)
  );

`ifdef DEC_KEY_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic to_load, to_done_c;

  // Inactivity count restarts on every strobe and whenever no wait state is active.
  assign to_load = bus.ValidCmd || !(state_q inside {ST_ENTRY, ST_ACTIVE});

  dec_key_timer #(.W(TO_W)) u_to_timer (
    .clk     (Clk),
    .rst_n   (Reset),
    .load    (to_load),
    .en      (1'b1),
    .load_val(TO_W'(TIMEOUT_CYCLES - 1)),
    .done_c  (to_done_c)
  );
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    fail_d  = fail_q;
    mode_d  = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ValidCmd) begin
          mis_d = bit_bad;
          if (KEY_LEN == 1) begin
            state_d = ST_CHECK;
            idx_d   = '0;
          end else begin
            state_d = ST_ENTRY;
            idx_d   = IDX_W'(1);
          end
        end
      end
      ST_ENTRY: begin
        if (bus.ValidCmd) begin
          mis_d = mis_q | bit_bad;
          if (idx_q == IDX_W'(KEY_LEN - 1)) begin
            state_d = ST_CHECK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
`ifdef DEC_KEY_TIMEOUT_EN
        else if (to_done_c) begin
          state_d = ST_CHECK;
          mis_d   = 1'b1;
          idx_d   = '0;
        end
`endif
      end
      ST_CHECK: begin
        mis_d = 1'b0;
        if (mis_q) begin
          error_d = 1'b1;
          fail_d  = fail_inc;
          state_d = (fail_inc == FAIL_W'(MAX_TRIES)) ? ST_LOCKED : ST_IDLE;
        end else begin
          fail_d  = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        mode_d = bus.ValidCmd ? bus.InputKey : mode_q;
`ifdef DEC_KEY_TIMEOUT_EN
        if (!bus.ValidCmd && to_done_c) begin
          state_d = ST_IDLE;
          mode_d  = 1'b0;
        end
`endif
      end
      ST_LOCKED: begin
        if (lock_done_c) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d == ST_ACTIVE);
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      fail_q   <= '0;
      active_q <= 1'b0;
      mode_q   <= 1'b0;
      error_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mis_q    <= mis_d;
      fail_q   <= fail_d;
      active_q <= active_d;
      mode_q   <= mode_d;
      error_q  <= error_d;
      locked_q <= locked_d;
    end
  end

  assign bus.Active  = active_q;
  assign bus.Mode    = mode_q;
  assign bus.Error   = error_q;
  assign bus.Locked  = locked_q;
  assign bus.FailCnt = fail_q;
endmodule

// File: tb/tb_key_sequence_decoder.sv
// Scoreboard bench for key_sequence_decoder: expected status vectors are queued per cycle
// as stimulus is driven and compared on the falling edge.
module tb_key_sequence_decoder;
  import dec_key_pkg::*;

  localparam int unsigned FAIL_W = 2;

  typedef struct packed {
    logic              active;
    logic              mode;
    logic              error;
    logic              locked;
    logic [FAIL_W-1:0] fail;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    obs_t        exp;
    string       tag;
  } sb_t;

  logic        Clk = 1'b0;
  logic        Reset;
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  sb_t         sb_q[$];

  key_sequence_decoder_if #(.FAIL_W(FAIL_W)) bus ();

  key_sequence_decoder #(
    .KEY_LEN       (4),
    .KEY_VALUE     (4'b1010),
    .MAX_TRIES     (3),
    .LOCK_CYCLES   (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic obs_t mk(input logic a, input logic m, input logic e, input logic l,
                              input logic [FAIL_W-1:0] f);
    mk = {a, m, e, l, f};
  endfunction

  function automatic obs_t cur_obs();
    cur_obs = {bus.Active, bus.Mode, bus.Error, bus.Locked, bus.FailCnt};
  endfunction

  task automatic expect_at(input int unsigned c, input obs_t o, input string tag);
    sb_t e;
    e.cyc = c;
    e.exp = o;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic expect_span(input int unsigned c0, input int unsigned c1, input obs_t o,
                             input string tag);
    for (int unsigned c = c0; c <= c1; c++) expect_at(c, o, tag);
  endtask

  // Compare every queued expectation due in this cycle.
  always @(negedge Clk) begin
    obs_t o;
    o = cur_obs();
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        check(sb_q[i].tag, 32'(o), 32'(sb_q[i].exp));
        sb_q.delete(i);
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.ValidCmd = 1'b1;
    bus.InputKey = b;
    @(posedge Clk);
    #1;
    bus.ValidCmd = 1'b0;
    bus.InputKey = 1'b0;
  endtask

  task automatic send_key(input logic [3:0] k, input bit chk_entry, input logic [FAIL_W-1:0] fc);
    for (int i = 3; i >= 0; i--) begin
      send_bit(k[i]);
      if (chk_entry) expect_at(cyc, mk(1'b0, 1'b0, 1'b0, 1'b0, fc), "entry_quiet");
    end
  endtask

  task automatic unlock(input logic [FAIL_W-1:0] fc);
    int unsigned e;
    send_key(4'b1010, 1'b1, fc);
    e = cyc;
    expect_at(e,     mk(1'b0, 1'b0, 1'b0, 1'b0, fc),   "check_cycle");
    expect_at(e + 1, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "unlock");
  endtask

  task automatic wrong_attempt(input logic [FAIL_W-1:0] fc);
    int unsigned e;
    logic [FAIL_W-1:0] fcn;
    send_key(4'b1110, 1'b1, fc);
    e   = cyc;
    fcn = fc + 2'd1;
    expect_at(e, mk(1'b0, 1'b0, 1'b0, 1'b0, fc), "wrong_check");
    if (fcn == 2'd3) begin
      expect_at(e + 1, mk(1'b0, 1'b0, 1'b1, 1'b1, fcn), "lock_error");
    end else begin
      expect_at(e + 1, mk(1'b0, 1'b0, 1'b1, 1'b0, fcn), "wrong_error");
      expect_at(e + 2, mk(1'b0, 1'b0, 1'b0, 1'b0, fcn), "wrong_idle");
    end
    idle(1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check(tag, 32'(cur_obs()), 32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0)));
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned m, e3;
    Reset        = 1'b0;
    bus.ValidCmd = 1'b0;
    bus.InputKey = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", 32'(cur_obs()), 32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0)));
    #1;
    Reset = 1'b1;
    idle(1);

    // Correct key, then Mode strobes with an idle gap.
    unlock(2'd0);
    idle(2);
    expect_at(cyc, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "mode_zero_on_entry");
    send_bit(1'b1);
    m = cyc;
    expect_span(m, m + 5, mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd0), "mode_one_hold");
    idle(5);
    send_bit(1'b0);
    expect_at(m + 6, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "mode_back_zero");
    idle(1);
    do_reset("reset_in_active");

    // One wrong key, then the correct one clears the count.
    wrong_attempt(2'd0);
    unlock(2'd1);
    idle(2);
    do_reset("reset_after_retry");

    // Three wrong keys lock out; a correct key during lockout is ignored.
    wrong_attempt(2'd0);
    wrong_attempt(2'd1);
    wrong_attempt(2'd2);
    e3 = cyc - 1;
    expect_span(e3 + 2, e3 + 16, mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd3), "locked_hold");
    expect_span(e3 + 17, e3 + 19, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0), "lock_release");
    send_key(4'b1010, 1'b0, 2'd0);
    idle(e3 + 19 - cyc);
    unlock(2'd0);
    idle(2);
    do_reset("reset_after_lock");

    // Reset mid-entry, then a full key still unlocks.
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset("reset_mid_entry");
    unlock(2'd0);
    idle(2);

`ifdef DEC_KEY_TIMEOUT_EN
    begin
      int unsigned b2, ea;
      do_reset("reset_before_timeout");
      send_bit(1'b1);
      send_bit(1'b0);
      b2 = cyc;
      expect_span(b2, b2 + 8, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0), "entry_wait");
      expect_at(b2 + 9,  mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1), "entry_timeout_error");
      expect_at(b2 + 10, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1), "entry_timeout_idle");
      idle(11);
      unlock(2'd1);
      ea = cyc;
      expect_span(ea + 2, ea + 8, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), "active_wait");
      expect_at(ea + 9, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0), "active_timeout");
      idle(10);
    end
`endif

    idle(2);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/key_sequence_decoder.md
# key_sequence_decoder

Parametrised serial key-entry decoder that generalises the fixed 4-bit unlock FSM. It checks a KEY_LEN-bit key sampled one bit per ValidCmd strobe, counts failed attempts, and locks out entry for a fixed number of cycles after MAX_TRIES failures. Once unlocked it holds a registered Mode bit driven by subsequent commands. It sits between the command front-end (InputKey/ValidCmd) and the mode-controlled datapath.

## Interface
- KEY_LEN, 4: key length in bits, ≥1; entered MSB first.
- KEY_VALUE, 4'b1010: expected key, KEY_LEN bits wide.
- MAX_TRIES, 3: failed attempts before lockout, ≥1.
- LOCK_CYCLES, 16: lockout duration in clocks, ≥1.
- TIMEOUT_CYCLES, 64: inactivity limit; used only with DEC_KEY_TIMEOUT_EN.
- Clk  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- InputKey  input  1  key or mode bit, sampled when ValidCmd=1.
- ValidCmd  input  1  command strobe; one bit consumed per cycle high.
- Active  output  1  unlocked.
- Mode  output  1  registered mode bit; valid while Active=1.
- Error  output  1  one-cycle pulse per failed attempt.
- Locked  output  1  lockout in progress.
- FailCnt  output  $clog2(MAX_TRIES+1)  consecutive failed attempts.

## Operation
- States: IDLE, ENTRY, CHECK, ACTIVE, LOCKED.
- Reset (Reset=0): state IDLE; bit index, FailCnt, lock/timeout counters, mismatch flag, and all outputs = 0.
- IDLE: ValidCmd=1 → compare InputKey to KEY_VALUE[KEY_LEN-1], set mismatch flag on difference, index=1. Go to ENTRY, or to CHECK if KEY_LEN=1.
- ENTRY: ValidCmd=0 → hold. ValidCmd=1 → compare bit KEY_LEN-1-index, OR result into the sticky mismatch flag. Index reaches KEY_LEN → CHECK.
- A wrong bit does not abort entry: all KEY_LEN bits are always consumed, so the failing position is not leaked.
- CHECK (one cycle, ValidCmd ignored):
  - flag clear → ACTIVE, FailCnt=0.
  - flag set → Error pulse, FailCnt+1. If the new FailCnt equals MAX_TRIES → LOCKED; else → IDLE.
- LOCKED: Locked=1, ValidCmd ignored. After LOCK_CYCLES clocks → IDLE, FailCnt=0, Locked=0.
- ACTIVE: Active=1. Each ValidCmd=1 loads Mode ← InputKey. Mode holds between strobes and is 0 on entry. ACTIVE persists until reset (or timeout, see Configuration).
- Mode is forced to 0 outside ACTIVE.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Active rises 2 edges after the edge that samples the last key bit (sample → CHECK → ACTIVE).
- Error is high for exactly the cycle the FSM is in LOCKED or IDLE after CHECK, i.e. 2 edges after the last bit.
- Locked rises together with that Error pulse and stays high for exactly LOCK_CYCLES cycles.
- Mode updates on the edge that samples ValidCmd=1 in ACTIVE.
- Back-to-back ValidCmd is legal, one bit per cycle. A strobe during CHECK is dropped.
- Reset asserted mid-entry, mid-lockout or in ACTIVE returns everything to reset values immediately (asynchronously).
- FailCnt saturates at MAX_TRIES and never wraps.

## Configuration
- DEC_KEY_TIMEOUT_EN defined: an inactivity counter clears on every ValidCmd=1 and increments otherwise.
  - In ENTRY, reaching TIMEOUT_CYCLES goes to CHECK with the mismatch flag forced set, so it counts as a failed attempt.
  - In ACTIVE, reaching it goes to IDLE with Active=0 and Mode=0; FailCnt is unchanged.
- DEC_KEY_TIMEOUT_EN undefined: no timeout counter is built; ENTRY and ACTIVE wait indefinitely; TIMEOUT_CYCLES is ignored.

## Structure
- Package dec_key_pkg holds:
  - the state enum (IDLE, ENTRY, CHECK, ACTIVE, LOCKED);
  - default KEY_LEN, KEY_VALUE, MAX_TRIES, LOCK_CYCLES and TIMEOUT_CYCLES constants.
- Sub-module dec_key_timer: a loadable down-counter with a done flag. It is instantiated for lockout and, under the macro, a second time for inactivity timeout.

## Test plan
- Defaults, key 1,0,1,0 on 4 consecutive strobes → Active=1 two edges after the 4th bit; Error never pulses; FailCnt=0.
- Key 1,1,1,0 → no early abort; Error pulses once two edges after the 4th bit; FailCnt=1; state returns to IDLE; then correct key → Active=1, FailCnt=0.
- Three wrong keys → third Error pulse with Locked=1 and FailCnt=3. Correct key during lockout is ignored. Locked drops after exactly 16 cycles with FailCnt=0; correct key then unlocks.
- In ACTIVE, strobes InputKey=1, gap of 5 idle cycles, then InputKey=0 → Mode = 1, holds 1 during the gap, then 0, each change one edge after its strobe.
- Reset pulsed low after 2 correct bits → all outputs 0 at once; a full correct key afterwards still unlocks.
- With DEC_KEY_TIMEOUT_EN and TIMEOUT_CYCLES=8: 2 bits then 8 idle cycles → Error pulse, FailCnt=1. Once ACTIVE, 8 idle cycles → Active=0.
